safe_code_checker: RTL and testbench



---
 rtl/safe_pkg.sv | 17 +
 rtl/cmp4.sv | 12 +
 rtl/safe_down_counter.sv | 27 ++
 rtl/safe_code_checker.sv | 193 +++++++++++++++++++
 tb/tb_safe_code_checker.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_pkg.sv
// Shared types and constants for the safe code checker block.
package safe_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_FAIL    = 3'd3,
    ST_OPEN    = 3'd4,
    ST_PROGRAM = 3'd5,
    ST_LOCKOUT = 3'd6
  } state_e;

endpackage

// File: rtl/cmp4.sv
// 4-bit magnitude comparator: equality and a-greater-than-b.
module cmp4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       eq_o,
  output logic       gt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/safe_down_counter.sv
// Loadable down-counter; tc_o pulses while enabled at zero.
module safe_down_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/safe_code_checker.sv
// Sequential keypad code checker with lockout and reprogramming.
// Optional SAFE_AUTO_RELOCK_EN adds an automatic relock timer in OPEN.
module safe_code_checker
  import safe_pkg::*;
#(
  parameter int unsigned            CODE_LEN       = 4,
  parameter int unsigned            MAX_TRIES      = 3,
  parameter int unsigned            LOCKOUT_CYCLES = 1000,
  parameter logic [4*CODE_LEN-1:0]  DEFAULT_CODE   = 16'h1234
`ifdef SAFE_AUTO_RELOCK_EN
  , parameter int unsigned          RELOCK_CYCLES  = 5000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       lock_cmd,
  input  logic       prog_cmd,
  output logic       unlocked,
  output logic       error,
  output logic       locked_out,
  output logic       prog_active,
  output logic [3:0] tries,
  output logic [2:0] entry_idx
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CODE_W = DIGIT_W * CODE_LEN;
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q, shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q;
  logic                mismatch_q;
  logic [3:0]          tries_q;
  logic                unlocked_q, error_q, locked_out_q, prog_q;

  logic [DIGIT_W-1:0]  stored_digit;
  logic                digit_eq, digit_gt, unused_eq_gt, unused_gt_eq;
  logic                digit_ok, digit_bad, last_digit;
  logic                lock_load, lock_tc;

  // Selects stored[idx] (digit 0 in the MS nibble) and builds the shadow update.
  always_comb begin
    stored_digit = '0;
    shadow_d     = shadow_q;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        stored_digit = code_q[DIGIT_W*(CODE_LEN-1-i) +: DIGIT_W];
        shadow_d[DIGIT_W*(CODE_LEN-1-i) +: DIGIT_W] = digit;
      end
    end
  end

  cmp4 u_cmp_eq (.a_i(digit), .b_i(stored_digit), .eq_o(digit_eq), .gt_o(unused_eq_gt));
  cmp4 u_cmp_gt (.a_i(digit), .b_i(BCD_MAX),      .eq_o(unused_gt_eq), .gt_o(digit_gt));

  assign digit_ok   = digit_valid && !digit_gt;
  assign digit_bad  = digit_valid && digit_gt;
  assign last_digit = (idx_q == IDX_W'(CODE_LEN - 1));
  assign lock_load  = (state_q == ST_CHECK) && mismatch_q && (tries_q >= 4'(MAX_TRIES - 1));

  safe_down_counter #(.W(LOCK_W)) u_lock_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lock_load),
    .load_val_i (LOCK_W'(LOCKOUT_CYCLES - 1)),
    .en_i       (state_q == ST_LOCKOUT),
    .tc_o       (lock_tc)
  );

`ifdef SAFE_AUTO_RELOCK_EN
  localparam int unsigned RELOCK_W = $clog2(RELOCK_CYCLES);
  logic enter_open, relock_tc;

  // Every transition into OPEN reloads; PROGRAM never enables the count.
  assign enter_open = ((state_q == ST_CHECK) && !mismatch_q) ||
                      ((state_q == ST_PROGRAM) && (clear || (digit_ok && last_digit)));

  safe_down_counter #(.W(RELOCK_W)) u_relock_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (enter_open),
    .load_val_i (RELOCK_W'(RELOCK_CYCLES - 1)),
    .en_i       ((state_q == ST_OPEN) && !lock_cmd && !prog_cmd),
    .tc_o       (relock_tc)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      tries_q      <= '0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
      prog_q       <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (clear) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end else if (digit_bad) begin
            error_q <= 1'b1;
          end else if (digit_ok) begin
            if (!digit_eq) mismatch_q <= 1'b1;
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= last_digit ? ST_CHECK : ST_ENTRY;
          end
        end
        ST_CHECK: begin
          idx_q      <= '0;
          mismatch_q <= 1'b0;
          if (!mismatch_q) begin
            state_q    <= ST_OPEN;
            tries_q    <= '0;
            unlocked_q <= 1'b1;
          end else if (tries_q >= 4'(MAX_TRIES - 1)) begin
            state_q      <= ST_LOCKOUT;
            tries_q      <= 4'(MAX_TRIES);
            locked_out_q <= 1'b1;
          end else begin
            state_q <= ST_FAIL;
            tries_q <= tries_q + 4'd1;
            error_q <= 1'b1;
          end
        end
        ST_FAIL: state_q <= ST_IDLE;
        ST_OPEN: begin
          if (lock_cmd) begin
            state_q    <= ST_IDLE;
            unlocked_q <= 1'b0;
          end else if (prog_cmd) begin
            state_q  <= ST_PROGRAM;
            prog_q   <= 1'b1;
            idx_q    <= '0;
            shadow_q <= '0;
          end
`ifdef SAFE_AUTO_RELOCK_EN
          else if (relock_tc) begin
            state_q    <= ST_IDLE;
            unlocked_q <= 1'b0;
          end
`endif
        end
        ST_PROGRAM: begin
          if (clear) begin
            state_q  <= ST_OPEN;
            prog_q   <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
          end else if (digit_bad) begin
            error_q <= 1'b1;
          end else if (digit_ok) begin
            shadow_q <= shadow_d;
            idx_q    <= idx_q + IDX_W'(1);
            if (last_digit) begin
              code_q  <= shadow_d;
              idx_q   <= '0;
              prog_q  <= 1'b0;
              state_q <= ST_OPEN;
            end
          end
        end
        ST_LOCKOUT: begin
          if (lock_tc) begin
            state_q      <= ST_IDLE;
            tries_q      <= '0;
            locked_out_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unlocked    = unlocked_q;
  assign error       = error_q;
  assign locked_out  = locked_out_q;
  assign prog_active = prog_q;
  assign tries       = tries_q;
  assign entry_idx   = idx_q[2:0];

endmodule

// File: tb/tb_safe_code_checker.sv
// Self-checking bench for safe_code_checker against a code/attempt-level model.
module tb_safe_code_checker;

  localparam int unsigned CL = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned LC = 1000;
  localparam int unsigned RC = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit;
  logic       digit_valid, clear, lock_cmd, prog_cmd;
  logic       unlocked, error, locked_out, prog_active;
  logic [3:0] tries;
  logic [2:0] entry_idx;

  int cmp_n = 0;
  int bad_n = 0;
  int err_pulses = 0;
  logic [4*CL-1:0] m_code;
  int m_tries;

  safe_code_checker #(
    .CODE_LEN       (CL),
    .MAX_TRIES      (MT),
    .LOCKOUT_CYCLES (LC),
    .DEFAULT_CODE   (16'h1234)
`ifdef SAFE_AUTO_RELOCK_EN
    , .RELOCK_CYCLES (RC)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit       (digit),
    .digit_valid (digit_valid),
    .clear       (clear),
    .lock_cmd    (lock_cmd),
    .prog_cmd    (prog_cmd),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out),
    .prog_active (prog_active),
    .tries       (tries),
    .entry_idx   (entry_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && error === 1'b1) err_pulses++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    digit = '0;
  endtask

  task automatic do_lock();
    lock_cmd = 1'b1;
    step();
    lock_cmd = 1'b0;
  endtask

  // Returns positioned in the cycle right after the last digit strobe.
  task automatic enter_code(input logic [4*CL-1:0] code, input bit inject, output int n_bad);
    logic [4*CL-1:0] c;
    c = code;
    n_bad = 0;
    for (int i = 0; i < int'(CL); i++) begin
      repeat ($urandom_range(2)) step();
      if (inject && $urandom_range(3) == 0) begin
        press(4'(10 + $urandom_range(5)));
        n_bad++;
      end
      press(c[4*CL-1 -: 4]);
      c = c << 4;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    digit = '0; digit_valid = 1'b0; clear = 1'b0; lock_cmd = 1'b0; prog_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_code = 16'h1234;
    m_tries = 0;
    step();
    cmp_n++;
    if ({unlocked, error, locked_out, prog_active, tries, entry_idx} !== 14'd0) begin
      bad_n++;
      $display("FAIL reset_outputs: got %b want all zero",
               {unlocked, error, locked_out, prog_active, tries, entry_idx});
    end
  endtask

  task automatic test_correct_code();
    int p0, nb;
    p0 = err_pulses;
    enter_code(m_code, 1'b0, nb);
    cmp_n++;
    if (unlocked !== 1'b0) begin
      bad_n++; $display("FAIL correct_latency_early: unlocked=%b want 0", unlocked);
    end
    step();
    cmp_n++;
    if (unlocked !== 1'b1 || tries !== 4'd0) begin
      bad_n++; $display("FAIL correct_unlock: unlocked=%b tries=%0d want 1/0", unlocked, tries);
    end
    do_lock();
    cmp_n++;
    if (unlocked !== 1'b0 || err_pulses != p0) begin
      bad_n++; $display("FAIL correct_relock: unlocked=%b pulses=%0d want 0/0", unlocked, err_pulses - p0);
    end
  endtask

  task automatic test_wrong_lockout();
    int p0, nb, n;
    p0 = err_pulses;
    for (int a = 1; a <= int'(MT); a++) begin
      enter_code(16'h1235, 1'b0, nb);
      m_tries++;
      step();
      if (m_tries < int'(MT)) begin
        cmp_n++;
        if (error !== 1'b1 || tries !== 4'(m_tries)) begin
          bad_n++; $display("FAIL wrong_attempt_%0d: error=%b tries=%0d want 1/%0d", a, error, tries, m_tries);
        end
        step();
      end else begin
        cmp_n++;
        if (locked_out !== 1'b1 || tries !== 4'(MT)) begin
          bad_n++; $display("FAIL lockout_entry: locked_out=%b tries=%0d want 1/%0d", locked_out, tries, MT);
        end
      end
    end
    n = 0;
    while (locked_out === 1'b1 && n < int'(LC) + 100) begin
      n++;
      digit = 4'($urandom_range(9));
      digit_valid = 1'($urandom_range(1));
      clear = 1'($urandom_range(1));
      lock_cmd = 1'($urandom_range(1));
      prog_cmd = 1'($urandom_range(1));
      step();
    end
    digit_valid = 1'b0; clear = 1'b0; lock_cmd = 1'b0; prog_cmd = 1'b0;
    m_tries = 0;
    cmp_n++;
    if (n != int'(LC)) begin
      bad_n++; $display("FAIL lockout_length: got %0d cycles want %0d", n, LC);
    end
    cmp_n++;
    if (tries !== 4'd0 || entry_idx !== 3'd0 || unlocked !== 1'b0) begin
      bad_n++; $display("FAIL lockout_exit: tries=%0d idx=%0d unlocked=%b want 0/0/0", tries, entry_idx, unlocked);
    end
    cmp_n++;
    if (err_pulses - p0 != int'(MT) - 1) begin
      bad_n++; $display("FAIL lockout_err_pulses: got %0d want %0d", err_pulses - p0, MT - 1);
    end
  endtask

  task automatic test_clear_invalid();
    int nb;
    enter_code(16'h9999, 1'b0, nb);
    m_tries++;
    step();
    step();
    press(4'd1);
    press(4'hA);
    cmp_n++;
    if (error !== 1'b1 || entry_idx !== 3'd1) begin
      bad_n++; $display("FAIL invalid_digit: error=%b idx=%0d want 1/1", error, entry_idx);
    end
    press(4'd2);
    cmp_n++;
    if (error !== 1'b0 || entry_idx !== 3'd2) begin
      bad_n++; $display("FAIL entry_progress: error=%b idx=%0d want 0/2", error, entry_idx);
    end
    clear = 1'b1; digit = 4'd3; digit_valid = 1'b1;
    step();
    clear = 1'b0; digit_valid = 1'b0;
    cmp_n++;
    if (entry_idx !== 3'd0 || tries !== 4'(m_tries)) begin
      bad_n++; $display("FAIL clear_entry: idx=%0d tries=%0d want 0/%0d", entry_idx, tries, m_tries);
    end
    enter_code(m_code, 1'b0, nb);
    step();
    m_tries = 0;
    cmp_n++;
    if (unlocked !== 1'b1 || tries !== 4'd0) begin
      bad_n++; $display("FAIL unlock_after_clear: unlocked=%b tries=%0d want 1/0", unlocked, tries);
    end
    do_lock();
  endtask

  task automatic test_reprogram();
    int nb;
    enter_code(m_code, 1'b0, nb);
    step();
    prog_cmd = 1'b1; step(); prog_cmd = 1'b0;
    cmp_n++;
    if (prog_active !== 1'b1 || unlocked !== 1'b1) begin
      bad_n++; $display("FAIL prog_enter: prog=%b unlocked=%b want 1/1", prog_active, unlocked);
    end
    press(4'd9); press(4'd8); press(4'd7);
    cmp_n++;
    if (prog_active !== 1'b1) begin
      bad_n++; $display("FAIL prog_partial: prog=%b want 1", prog_active);
    end
    press(4'd6);
    m_code = 16'h9876;
    cmp_n++;
    if (prog_active !== 1'b0 || unlocked !== 1'b1) begin
      bad_n++; $display("FAIL prog_commit: prog=%b unlocked=%b want 0/1", prog_active, unlocked);
    end
    prog_cmd = 1'b1; step(); prog_cmd = 1'b0;
    press(4'd1);
    clear = 1'b1; step(); clear = 1'b0;
    cmp_n++;
    if (prog_active !== 1'b0 || unlocked !== 1'b1) begin
      bad_n++; $display("FAIL prog_clear: prog=%b unlocked=%b want 0/1", prog_active, unlocked);
    end
    do_lock();
    enter_code(16'h1234, 1'b0, nb);
    step();
    m_tries++;
    cmp_n++;
    if (error !== 1'b1 || unlocked !== 1'b0 || tries !== 4'(m_tries)) begin
      bad_n++; $display("FAIL old_code_rejected: error=%b unlocked=%b tries=%0d want 1/0/%0d",
                        error, unlocked, tries, m_tries);
    end
    step();
    enter_code(m_code, 1'b0, nb);
    step();
    m_tries = 0;
    cmp_n++;
    if (unlocked !== 1'b1 || tries !== 4'd0) begin
      bad_n++; $display("FAIL new_code_accepted: unlocked=%b tries=%0d want 1/0", unlocked, tries);
    end
    do_lock();
  endtask

  task automatic test_reset_mid();
    int nb;
    enter_code(m_code, 1'b0, nb);
    step();
    prog_cmd = 1'b1; step(); prog_cmd = 1'b0;
    press(4'd5); press(4'd5);
    rst_n = 1'b0;
    #1;
    cmp_n++;
    if ({unlocked, error, locked_out, prog_active, tries, entry_idx} !== 14'd0) begin
      bad_n++; $display("FAIL async_reset: got %b want all zero",
                        {unlocked, error, locked_out, prog_active, tries, entry_idx});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_code = 16'h1234;
    m_tries = 0;
    step();
    enter_code(16'h1234, 1'b0, nb);
    step();
    cmp_n++;
    if (unlocked !== 1'b1) begin
      bad_n++; $display("FAIL default_code_restored: unlocked=%b want 1", unlocked);
    end
    do_lock();
  endtask

  task automatic test_open_hold();
    int nb, n;
    enter_code(m_code, 1'b0, nb);
    step();
`ifdef SAFE_AUTO_RELOCK_EN
    n = 0;
    while (unlocked === 1'b1 && n < int'(RC) + 50) begin
      n++;
      step();
    end
    cmp_n++;
    if (n != int'(RC)) begin
      bad_n++; $display("FAIL auto_relock: open for %0d cycles want %0d", n, RC);
    end
`else
    n = 0;
    repeat (100) begin
      if (unlocked === 1'b1) n++;
      step();
    end
    cmp_n++;
    if (n != 100 || unlocked !== 1'b1) begin
      bad_n++; $display("FAIL open_persists: open cycles=%0d unlocked=%b want 100/1", n, unlocked);
    end
    do_lock();
`endif
  endtask

  task automatic test_random();
    logic [4*CL-1:0] code;
    int p0, nb, exp_p, n;
    bit match;
    for (int r = 0; r < 14; r++) begin
      p0 = err_pulses;
      exp_p = 0;
      if ($urandom_range(1) == 1) begin
        code = m_code;
      end else begin
        code = '0;
        for (int i = 0; i < int'(CL); i++) code = {code[4*CL-5:0], 4'($urandom_range(9))};
      end
      match = (code == m_code);
      enter_code(code, 1'b1, nb);
      exp_p += nb;
      step();
      if (match) begin
        m_tries = 0;
        cmp_n++;
        if (unlocked !== 1'b1 || tries !== 4'd0) begin
          bad_n++; $display("FAIL rnd_open_%0d: unlocked=%b tries=%0d want 1/0", r, unlocked, tries);
        end
        do_lock();
      end else begin
        m_tries++;
        if (m_tries >= int'(MT)) begin
          cmp_n++;
          if (locked_out !== 1'b1 || tries !== 4'(MT)) begin
            bad_n++; $display("FAIL rnd_lockout_%0d: locked_out=%b tries=%0d want 1/%0d", r, locked_out, tries, MT);
          end
          n = 0;
          while (locked_out === 1'b1 && n < int'(LC) + 100) begin
            n++;
            step();
          end
          m_tries = 0;
        end else begin
          exp_p++;
          cmp_n++;
          if (error !== 1'b1 || tries !== 4'(m_tries)) begin
            bad_n++; $display("FAIL rnd_reject_%0d: error=%b tries=%0d want 1/%0d", r, error, tries, m_tries);
          end
          step();
        end
      end
      cmp_n++;
      if (err_pulses - p0 != exp_p || tries !== 4'(m_tries) || unlocked !== 1'b0) begin
        bad_n++; $display("FAIL rnd_round_%0d: pulses=%0d tries=%0d unlocked=%b want %0d/%0d/0",
                          r, err_pulses - p0, tries, unlocked, exp_p, m_tries);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_lockout();
    test_clear_invalid();
    test_reprogram();
    test_reset_mid();
    test_open_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
